// File: rtl/de0_rstseq.sv
// de0_rstseq: PLL reset sequencer with lock-hold release, relock counter and debounced user reset key.
// Define RSTSEQ_WATCHDOG_EN to restart the PLL when lock does not arrive within LOCK_TIMEOUT cycles.
module de0_rstseq #(
    parameter int PLLRST_CYC   = 16,
    parameter int LOCK_TIMEOUT = 50000,
    parameter int HOLD_CYC     = 1024,
    parameter int DEB_CYC      = 250000
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       locked,
    input  logic       key_n,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic [7:0] relock_cnt,
    output logic [1:0] state
);
    localparam int MAX_A   = (PLLRST_CYC > LOCK_TIMEOUT) ? PLLRST_CYC : LOCK_TIMEOUT;
    localparam int MAX_CYC = (MAX_A > HOLD_CYC) ? MAX_A : HOLD_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int DEB_W   = $clog2(DEB_CYC + 1);

    typedef enum logic [1:0] {
        ST_PLLRST = 2'd0,
        ST_WAIT   = 2'd1,
        ST_HOLD   = 2'd2,
        ST_RUN    = 2'd3
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic locked_m, locked_s;
    logic key_m, key_s;

    always_ff @(posedge clkin) begin
        if (rst) begin
            locked_m <= 1'b0;
            locked_s <= 1'b0;
            key_m    <= 1'b0;
            key_s    <= 1'b0;
        end else begin
            locked_m <= locked;
            locked_s <= locked_m;
            key_m    <= key_n;
            key_s    <= key_m;
        end
    end

    // Debounce: accept key_s only after it disagrees with key_db for DEB_CYC straight cycles.
    logic [DEB_W-1:0] deb_cnt;
    logic             key_db;
    logic             press;

    always_ff @(posedge clkin) begin
        if (rst) begin
            deb_cnt <= '0;
            key_db  <= 1'b1;
            press   <= 1'b0;
        end else begin
            press <= 1'b0;
            if (key_s != key_db) begin
                if (deb_cnt == DEB_W'(DEB_CYC - 1)) begin
                    key_db  <= key_s;
                    deb_cnt <= '0;
                    press   <= ~key_s;
                end else begin
                    deb_cnt <= deb_cnt + DEB_W'(1);
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    state_t           state_q, state_n;
    logic [CNT_W-1:0] cnt;
    logic             cnt_clr;
    logic             relock_inc;

    always_comb begin
        state_n    = state_q;
        cnt_clr    = 1'b0;
        relock_inc = 1'b0;
        case (state_q)
            ST_PLLRST: begin
                if (cnt == CNT_W'(PLLRST_CYC - 1)) state_n = ST_WAIT;
            end
            ST_WAIT: begin
                if (locked_s) state_n = ST_HOLD;
`ifdef RSTSEQ_WATCHDOG_EN
                else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) state_n = ST_PLLRST;
`endif
            end
            ST_HOLD: begin
                if (!locked_s) state_n = ST_WAIT;
                else if (press) cnt_clr = 1'b1;
                else if (cnt == CNT_W'(HOLD_CYC - 1)) state_n = ST_RUN;
            end
            ST_RUN: begin
                if (!locked_s) begin
                    state_n    = ST_PLLRST;
                    relock_inc = 1'b1;
                end else if (press) begin
                    state_n = ST_HOLD;
                end
            end
            default: state_n = ST_PLLRST;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as state.
    always_ff @(posedge clkin) begin
        if (rst) begin
            state_q    <= ST_PLLRST;
            cnt        <= '0;
            pll_rst    <= 1'b1;
            sys_rst    <= 1'b1;
            ready      <= 1'b0;
            relock_cnt <= '0;
        end else begin
            state_q <= state_n;
            cnt     <= (cnt_clr || (state_n != state_q)) ? '0 : cnt + CNT_W'(1);
            pll_rst <= (state_n == ST_PLLRST);
            sys_rst <= (state_n != ST_RUN);
            ready   <= (state_n == ST_RUN);
            if (relock_inc) relock_cnt <= sat_inc8(relock_cnt);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_de0_rstseq.sv
// Testbench for de0_rstseq: directed scenarios plus random lock/key activity against a timeline model.
module tb_de0_rstseq;
    localparam int P_PLL  = 4;
    localparam int P_TO   = 20;
    localparam int P_HOLD = 8;
    localparam int P_DEB  = 3;

    logic       clkin = 1'b0;
    logic       rst, locked, key_n;
    logic       pll_rst, sys_rst, ready;
    logic [7:0] relock_cnt;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    de0_rstseq #(
        .PLLRST_CYC  (P_PLL),
        .LOCK_TIMEOUT(P_TO),
        .HOLD_CYC    (P_HOLD),
        .DEB_CYC     (P_DEB)
    ) dut (
        .clkin     (clkin),
        .rst       (rst),
        .locked    (locked),
        .key_n     (key_n),
        .pll_rst   (pll_rst),
        .sys_rst   (sys_rst),
        .ready     (ready),
        .relock_cnt(relock_cnt),
        .state     (state)
    );

    always #5 clkin = ~clkin;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: phases 0..3 with an entry timestamp; dwell time is edges since entry.
    int   cyc = 0;
    int   m_ph, t_ent, m_relock, m_run, m_dur, m_nph;
    logic lh0, lh1, kh0, kh1, m_db, m_press_nx, m_ls, m_ks, m_pr;
    bit   mvalid = 0;

    always @(posedge clkin) begin
        cyc++;
        if (rst) begin
            m_ph = 0; t_ent = cyc; m_relock = 0;
            lh0 = 0; lh1 = 0; kh0 = 0; kh1 = 0;
            m_db = 1; m_run = 0; m_press_nx = 0;
            mvalid = 1;
        end else if (mvalid) begin
            m_ls = lh1; m_ks = kh1; m_pr = m_press_nx;
            lh1 = lh0; lh0 = locked; kh1 = kh0; kh0 = key_n;
            m_press_nx = 0;
            if (m_ks != m_db) begin
                m_run++;
                if (m_run == P_DEB) begin
                    m_db = m_ks; m_run = 0; m_press_nx = !m_ks;
                end
            end else m_run = 0;
            m_dur = cyc - t_ent;
            m_nph = m_ph;
            case (m_ph)
                0: if (m_dur == P_PLL) m_nph = 1;
                1: begin
                    if (m_ls) m_nph = 2;
`ifdef RSTSEQ_WATCHDOG_EN
                    else if (m_dur == P_TO) m_nph = 0;
`endif
                end
                2: begin
                    if (!m_ls) m_nph = 1;
                    else if (m_pr) t_ent = cyc;
                    else if (m_dur == P_HOLD) m_nph = 3;
                end
                default: begin
                    if (!m_ls) begin
                        m_nph = 0;
                        if (m_relock < 255) m_relock++;
                    end else if (m_pr) m_nph = 2;
                end
            endcase
            if (m_nph != m_ph) begin
                m_ph = m_nph; t_ent = cyc;
            end
        end
    end

    always @(negedge clkin) begin
        if (mvalid) begin
            check("state", int'(state), m_ph);
            check("pll_rst", int'(pll_rst), int'(m_ph == 0));
            check("sys_rst", int'(sys_rst), int'(m_ph != 3));
            check("ready", int'(ready), int'(m_ph == 3));
            check("relock_cnt", int'(relock_cnt), m_relock);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clkin);
        #2;
    endtask

    task automatic wait_state(input int tgt, input string nm, output int n);
        n = 0;
        while (int'(state) != tgt && n < 500) begin
            tick(1);
            n++;
        end
        if (int'(state) != tgt) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: state=%0d, required %0d", nm, state, tgt);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    int  n, pw, hi, nr, r0, r1, lock_left, key_left;
    logic prev;

    initial begin
        rst = 1'b1; locked = 1'b0; key_n = 1'b1;
        tick(3);
        check("reset_state", int'(state), 0);
        check("reset_pll_rst", int'(pll_rst), 1);
        check("reset_sys_rst", int'(sys_rst), 1);
        check("reset_ready", int'(ready), 0);
        check("reset_relock", int'(relock_cnt), 0);

        // Normal bring-up
        rst = 1'b0;
        pw = 0;
        for (int i = 0; i < 10; i++) begin
            pw += int'(pll_rst);
            tick(1);
        end
        check("bringup_pll_width", pw, 4);
        locked = 1'b1;
        wait_state(3, "bringup_ready", n);
        check("bringup_ready_latency", n, 11);
        check("bringup_relock", int'(relock_cnt), 0);

        // Lock loss in RUN, repeated to saturation
        for (int i = 0; i < 300; i++) begin
            wait_state(3, "relock_ready", n);
            locked = 1'b0;
            tick(1);
            locked = 1'b1;
            tick(1);
            if (i == 0) check("loss_no_early_sysrst", int'(sys_rst), 0);
            tick(1);
            if (i == 0) begin
                check("loss_sysrst", int'(sys_rst), 1);
                check("loss_state", int'(state), 0);
                check("loss_relock", int'(relock_cnt), 1);
            end
        end
        wait_state(3, "relock_final_ready", n);
        check("relock_saturated", int'(relock_cnt), 255);
        check("model_relock_saturated", m_relock, 255);

        // HOLD dropout at hold count 5
        rst = 1'b1;
        tick(1);
        check("rst_clears_relock", int'(relock_cnt), 0);
        rst = 1'b0;
        wait_state(2, "dropout_hold", n);
        tick(3);
        locked = 1'b0;
        tick(1);
        locked = 1'b1;
        tick(2);
        check("dropout_to_wait", int'(state), 1);
        wait_state(3, "dropout_ready", n);
        check("dropout_full_hold", n, 9);

        // Button: bounces then a steady press
        for (int i = 0; i < 4; i++) begin
            key_n = 1'b0; tick(2);
            key_n = 1'b1; tick(2);
        end
        tick(6);
        check("bounce_no_event", int'(state), 3);
        key_n = 1'b0;
        wait_state(2, "press_hold", n);
        check("press_latency", n, 6);
        check("press_pll_rst", int'(pll_rst), 0);
        check("press_sys_rst", int'(sys_rst), 1);
        wait_state(3, "press_ready", n);
        check("press_hold_len", n, 8);
        key_n = 1'b1;
        tick(10);
        check("release_no_event", int'(state), 3);

        // Press and lock loss on the same edge in RUN
        key_n = 1'b0;
        tick(3);
        locked = 1'b0;
        tick(1);
        locked = 1'b1;
        tick(2);
        check("simul_state", int'(state), 0);
        check("simul_relock", int'(relock_cnt), 1);
        key_n = 1'b1;
        tick(10);

        // rst asserted in HOLD
        wait_state(2, "rst_in_hold", n);
        rst = 1'b1;
        tick(1);
        check("hold_rst_state", int'(state), 0);
        check("hold_rst_pll_rst", int'(pll_rst), 1);
        check("hold_rst_sys_rst", int'(sys_rst), 1);
        check("hold_rst_ready", int'(ready), 0);
        check("hold_rst_relock", int'(relock_cnt), 0);

        // No lock at all: watchdog behaviour
        locked = 1'b0;
        tick(1);
        rst = 1'b0;
        hi = 0; nr = 0; r0 = 0; r1 = 0; prev = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (pll_rst) hi++;
            if (pll_rst && !prev) begin
                if (nr == 0) r0 = i;
                else if (nr == 1) r1 = i;
                nr++;
            end
            prev = pll_rst;
            tick(1);
        end
`ifdef RSTSEQ_WATCHDOG_EN
        check("wd_pll_high_cycles", hi, 12);
        check("wd_pulses", nr, 3);
        check("wd_period", r1 - r0, 24);
`else
        check("nowd_pll_high_cycles", hi, 4);
        check("nowd_pulses", nr, 1);
        check("nowd_wait_forever", int'(state), 1);
`endif

        // Random lock, key and occasional reset activity
        lock_left = 0; key_left = 0;
        for (int i = 0; i < 4000; i++) begin
            if (lock_left == 0) begin
                locked = ($urandom_range(0, 99) < 75);
                lock_left = ($urandom_range(0, 3) == 0) ? 1 : int'($urandom_range(1, 40));
            end
            lock_left--;
            if (key_left == 0) begin
                key_n = ~key_n;
                key_left = int'($urandom_range(1, 8));
            end
            key_left--;
            rst = ($urandom_range(0, 499) == 0);
            tick(1);
        end
        rst = 1'b0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
